// File: rtl/tlc_pkg.sv
// Shared types and default timings for the traffic phase controller.
// Optional flash mode is compiled in with TLC_FLASH_EN.
package tlc_pkg;

  localparam int unsigned DefNumRoads   = 2;
  localparam int unsigned DefTimerW     = 8;
  localparam int unsigned DefGreenTicks = 20;
  localparam int unsigned DefYellowTicks = 4;
  localparam int unsigned DefAllredTicks = 2;
  localparam int unsigned DefPedTicks   = 10;

  typedef enum logic [2:0] {
    PhGreen  = 3'd0,
    PhYellow = 3'd1,
    PhAllred = 3'd2,
`ifdef TLC_FLASH_EN
    PhFlash  = 3'd4,
`endif
    PhPed    = 3'd3
  } phase_t;

  // Which lamp the owning road shows, plus the walk lamp.
  typedef struct packed {
    logic grn;
    logic yel;
    logic walk;
  } lamp_sel_t;

  function automatic lamp_sel_t phase_lamps(input phase_t ph);
    lamp_sel_t sel;
    sel = '0;
    case (ph)
      PhGreen:  sel.grn  = 1'b1;
      PhYellow: sel.yel  = 1'b1;
      PhPed:    sel.walk = 1'b1;
      default:  sel      = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Lamp/request bundle between the intersection top level and the phase controller.
// flash_req exists only when TLC_FLASH_EN is defined.
interface traffic_phase_ctrl_if #(
  parameter int unsigned NUM_ROADS = 2
);
  localparam int unsigned RW = $clog2(NUM_ROADS);

  logic                 tick;
  logic                 ped_req;
`ifdef TLC_FLASH_EN
  logic                 flash_req;
`endif
  logic [NUM_ROADS-1:0] green;
  logic [NUM_ROADS-1:0] yellow;
  logic [NUM_ROADS-1:0] red;
  logic                 ped_walk;
  logic                 ped_pending;
  logic [RW-1:0]        road_idx;

  modport master (
`ifdef TLC_FLASH_EN
    output flash_req,
`endif
    output tick,
    output ped_req,
    input  green,
    input  yellow,
    input  red,
    input  ped_walk,
    input  ped_pending,
    input  road_idx
  );

  modport slave (
`ifdef TLC_FLASH_EN
    input  flash_req,
`endif
    input  tick,
    input  ped_req,
    output green,
    output yellow,
    output red,
    output ped_walk,
    output ped_pending,
    output road_idx
  );

endinterface

// File: rtl/tlc_req_latch.sv
// Sticky request flag: synchronous set/clear with clear taking priority.
// Independent of TLC_FLASH_EN.
module tlc_req_latch (
  input  logic clk,
  input  logic reset_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_flag
);

  logic r_flag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flag <= 1'b0;
    end else if (i_clr) begin
      r_flag <= 1'b0;
    end else if (i_set) begin
      r_flag <= 1'b1;
    end
  end

  assign o_flag = r_flag;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin intersection controller: GREEN -> YELLOW -> ALLRED per road, PED walk after last road.
// TLC_FLASH_EN adds a flash_req-driven FLASH state with blinking lamps.
module traffic_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned NUM_ROADS    = DefNumRoads,
  parameter int unsigned TIMER_W      = DefTimerW,
  parameter int unsigned GREEN_TICKS  = DefGreenTicks,
  parameter int unsigned YELLOW_TICKS = DefYellowTicks,
  parameter int unsigned ALLRED_TICKS = DefAllredTicks,
  parameter int unsigned PED_TICKS    = DefPedTicks
) (
  input logic                 clk,
  input logic                 reset_n,
  traffic_phase_ctrl_if.slave bus
);

  localparam int unsigned   RW       = $clog2(NUM_ROADS);
  localparam logic [RW-1:0] LastRoad = RW'(NUM_ROADS - 1);

  phase_t               r_phase;
  logic [RW-1:0]        r_road;
  logic [TIMER_W-1:0]   r_timer;
`ifdef TLC_FLASH_EN
  logic                 r_blink;
`endif

  logic [TIMER_W-1:0]   w_dur_m1;
  logic                 w_phase_end;
  logic                 w_flash_req;
  logic                 w_pending;
  logic                 w_enter_ped;
  logic                 w_ped_set;
  lamp_sel_t            w_sel;
  logic [NUM_ROADS-1:0] w_onehot;
  logic [NUM_ROADS-1:0] w_green;
  logic [NUM_ROADS-1:0] w_yellow;
  logic [NUM_ROADS-1:0] w_red;

`ifdef TLC_FLASH_EN
  assign w_flash_req = bus.flash_req;
`else
  assign w_flash_req = 1'b0;
`endif

  always_comb begin
    w_dur_m1 = '0;
    case (r_phase)
      PhGreen:  w_dur_m1 = TIMER_W'(GREEN_TICKS - 1);
      PhYellow: w_dur_m1 = TIMER_W'(YELLOW_TICKS - 1);
      PhAllred: w_dur_m1 = TIMER_W'(ALLRED_TICKS - 1);
      PhPed:    w_dur_m1 = TIMER_W'(PED_TICKS - 1);
      default:  w_dur_m1 = '0;
    endcase
  end

  assign w_phase_end = bus.tick && (r_timer == w_dur_m1);
  assign w_enter_ped = !w_flash_req && (r_phase == PhAllred) && w_phase_end &&
                       (r_road == LastRoad) && w_pending;
  assign w_ped_set   = bus.ped_req && (r_phase != PhPed);

  tlc_req_latch u_ped_latch (
    .clk     (clk),
    .reset_n (reset_n),
    .i_set   (w_ped_set),
    .i_clr   (w_enter_ped),
    .o_flag  (w_pending)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= PhGreen;
      r_road  <= '0;
      r_timer <= '0;
`ifdef TLC_FLASH_EN
      r_blink <= 1'b1;
    end else if (w_flash_req) begin
      r_timer <= '0;
      if (r_phase != PhFlash) begin
        r_phase <= PhFlash;
        r_blink <= 1'b1;
      end else if (bus.tick) begin
        r_blink <= ~r_blink;
      end
    end else if (r_phase == PhFlash) begin
      // Leaving flash re-enters the cycle as if the last road just cleared.
      r_phase <= PhAllred;
      r_road  <= LastRoad;
      r_timer <= '0;
`endif
    end else begin
      if (bus.tick) begin
        r_timer <= r_timer + TIMER_W'(1);
      end
      case (r_phase)
        PhGreen: begin
          if (w_phase_end) begin
            r_phase <= PhYellow;
            r_timer <= '0;
          end
        end
        PhYellow: begin
          if (w_phase_end) begin
            r_phase <= PhAllred;
            r_timer <= '0;
          end
        end
        PhAllred: begin
          if (w_phase_end) begin
            r_timer <= '0;
            if (r_road != LastRoad) begin
              r_phase <= PhGreen;
              r_road  <= r_road + RW'(1);
            end else if (w_pending) begin
              r_phase <= PhPed;
            end else begin
              r_phase <= PhGreen;
              r_road  <= '0;
            end
          end
        end
        PhPed: begin
          if (w_phase_end) begin
            r_phase <= PhGreen;
            r_road  <= '0;
            r_timer <= '0;
          end
        end
        default: begin
          r_phase <= PhGreen;
          r_road  <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign w_sel    = phase_lamps(r_phase);
  assign w_onehot = NUM_ROADS'(1) << r_road;

  always_comb begin
    w_green  = w_sel.grn ? w_onehot : '0;
    w_yellow = w_sel.yel ? w_onehot : '0;
    w_red    = ~(w_green | w_yellow);
`ifdef TLC_FLASH_EN
    if (r_phase == PhFlash) begin
      w_green  = '0;
      w_yellow = r_blink ? NUM_ROADS'(1) : '0;
      w_red    = r_blink ? ~NUM_ROADS'(1) : '0;
    end
`endif
  end

  assign bus.green       = w_green;
  assign bus.yellow      = w_yellow;
  assign bus.red         = w_red;
  assign bus.ped_walk    = w_sel.walk;
  assign bus.ped_pending = w_pending;
  assign bus.road_idx    = r_road;

endmodule
